pio_bb_seq: RTL

//   Sequencer for one bidirectional PIO pad built on a BB buffer.

---
 rtl/pio_bb_seq_if.sv | 22 ++
 rtl/pio_bb_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pio_bb_seq_if.sv
// Request/response handshake bundle between user logic and the PIO pad sequencer.
interface pio_bb_seq_if;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic req_data;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_data;

  // User side: issues requests and consumes read results.
  modport master (
    output req_valid, req_write, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_write, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pio_bb_seq.sv
// Sequencer for one bidirectional PIO pad behind a BB buffer: turns single-bit
// read/write requests into drive / release / sample sequences with a
// guaranteed released gap after every write.
module pio_bb_seq #(
  parameter int HOLD_CYCLES = 1,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pio_bb_seq_if.slave bus,
  output logic        pad_i,
  output logic        pad_t,
  input  logic        pad_o,
  output logic        busy
);

  if (HOLD_CYCLES < 1 || TURN_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
    $error("pio_bb_seq: HOLD_CYCLES>=1, TURN_CYCLES>=1, SYNC_STAGES>=2 required");
  end

  localparam int CNT_MAX0 = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > SYNC_STAGES) ? CNT_MAX0 : SYNC_STAGES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    TURN,
    WAIT,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pad_i_q, pad_i_d;
  logic               pad_t_q, pad_t_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_data_q, rsp_data_d;
  logic               ready_q;
  logic               busy_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // pad_o crosses in asynchronously; shift it through the synchroniser every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_o};
    end
  end

  // State and registered outputs; reset releases the pad and drops any pending result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pad_i_q     <= 1'b1;
      pad_t_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pad_i_q     <= pad_i_d;
      pad_t_q     <= pad_t_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ready_q     <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Next-state and next-output decode; requests are only looked at while idle.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pad_i_d     = pad_i_q;
    pad_t_d     = pad_t_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_write) begin
            state_d = DRIVE;
            pad_i_d = bus.req_data;
            pad_t_d = 1'b0;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = WAIT;
            cnt_d   = SYNC_LD;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          pad_t_d = 1'b1;
          pad_i_d = 1'b1;
          cnt_d   = TURN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_data_d  = sync_out;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pad_t_d = 1'b1;
        pad_i_d = 1'b1;
      end
    endcase
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign pad_i         = pad_i_q;
  assign pad_t         = pad_t_q;
  assign busy          = busy_q;

endmodule
